memory_responder: RTL and testbench
===================================

Name: memory_responder

Overview:
- Memory-side responder to the CPU control unit's memory strobes. It owns the MAR/MDR pair and an internal word-addressed RAM.
- It completes read/write requests after a configurable number of wait states and signals completion with a one-cycle `done` pulse, which the control unit waits on before advancing.
- It sits between the shared 32-bit bus and main memory in the CPU datapath.

Parameters:
- ADDR_WIDTH, 9, MAR width. RAM depth is 2**ADDR_WIDTH words, so every address is in range.
- DATA_WIDTH, 32, word and bus width.
- WAIT_STATES, 2, extra cycles before the access is performed (0 allowed).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- mari  in  1  load MAR from bus_in[ADDR_WIDTH-1:0]
- mdri  in  1  load MDR from bus_in
- mdro  in  1  drive MDR onto bus_out
- read  in  1  start a read of mem[MAR] into MDR
- write  in  1  start a write of MDR into mem[MAR]
- bus_in  in  DATA_WIDTH  shared bus value
- bus_out  out  DATA_WIDTH  MDR when mdro=1, else 0 (combinational)
- busy  out  1  high while state != IDLE
- done  out  1  one-cycle completion pulse
- protocol_err  out  1  one-cycle pulse on an illegal request
- mar_q  out  ADDR_WIDTH  current MAR (debug)
- mdr_q  out  DATA_WIDTH  current MDR (debug)

Behaviour:
- Reset (async, high):
  - state=IDLE, MAR=0, MDR=0, counter=0, done=0, protocol_err=0.
  - RAM contents are not cleared.
  - Reset mid-operation aborts the request: no RAM write, no MDR update, no done pulse.
- States and transitions:
  - IDLE, READ_WAIT, WRITE_WAIT, DONE.
  - IDLE: read=1 -> READ_WAIT with counter=WAIT_STATES. write=1 (read=0) -> WRITE_WAIT with counter=WAIT_STATES.
  - READ_WAIT / WRITE_WAIT: if counter!=0, decrement and stay. If counter==0, perform the access and go to DONE.
    - Read access: MDR <= mem[MAR].
    - Write access: mem[MAR] <= MDR.
  - DONE: done=1 for exactly this cycle, then -> IDLE unconditionally.
- Latency:
  - done is registered (state==DONE).
  - With the request sampled at edge E, the access happens at edge E+WAIT_STATES+1 and done is high between edges E+WAIT_STATES+1 and E+WAIT_STATES+2.
  - For reads, MDR holds the read data in the same cycle done is high.
  - Back-to-back: a new request can be sampled at the edge that leaves DONE; it is accepted only once state==IDLE, i.e. the earliest next start is the edge after done falls.
- Register loads:
  - mari / mdri take effect only in IDLE.
  - In IDLE, mari and mdri on the same edge as a read/write: MAR/MDR load first, and the request uses the new values.
  - While busy, mari/mdri are ignored and protocol_err pulses 1 cycle.
- Request rules:
  - read=1 and write=1 together in IDLE: read wins, write is dropped, protocol_err pulses 1 cycle.
  - read/write while busy are ignored, and protocol_err pulses 1 cycle.
  - Strobes are level-sampled; holding read high through DONE starts a new read in the following IDLE cycle.
- bus_out = mdro ? MDR : 0, in all states.
- MAR wraps naturally, with no range check.

Test Plan:
1. Reset, then mari with bus_in=0x005, mdri with bus_in=0xDEADBEEF, then write (WAIT_STATES=2) -> busy high for 4 cycles, done pulse on the 3rd edge after write is sampled, mem[5]=0xDEADBEEF.
2. Then mdri with 0x0 and read at MAR=5 -> MDR=0xDEADBEEF exactly when done=1; with mdro=1, bus_out=0xDEADBEEF, and 0 when mdro=0.
3. WAIT_STATES=0: read sampled at edge E -> done high between E+1 and E+2; back-to-back reads at MAR=0x1FF and 0x000 both return the correct data.
4. read=1 and write=1 together in IDLE -> protocol_err pulse, read performed, mem unchanged; also mari during READ_WAIT -> MAR unchanged, protocol_err pulse.
5. Assert reset during WRITE_WAIT (counter=1) for address 7, holding 0x11111111 with 0x22222222 in MDR -> state IDLE, done never pulses, a later read of 7 returns 0x11111111, MAR=MDR=0.
6. mari with bus_in=0xFFFFFE05 (ADDR_WIDTH=9) -> MAR=0x005 (upper bits discarded).

Source files
------------

// File: rtl/memory_responder.sv
// Memory-side responder: owns MAR/MDR and a word-addressed RAM, completing
// control-unit read/write strobes after WAIT_STATES extra cycles with a done pulse.
module memory_responder #(
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  mari,
    input  logic                  mdri,
    input  logic                  mdro,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] bus_in,
    output logic [DATA_WIDTH-1:0] bus_out,
    output logic                  busy,
    output logic                  done,
    output logic                  protocol_err,
    output logic [ADDR_WIDTH-1:0] mar_q,
    output logic [DATA_WIDTH-1:0] mdr_q
);

    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_WAIT  = 2'd1,
        WRITE_WAIT = 2'd2,
        DONE       = 2'd3
    } state_t;

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  mem_we_d;
    logic                  strobe_any;

    assign strobe_any = mari | mdri | read | write;
    assign mem_we_d   = (state_q == WRITE_WAIT) && (cnt_q == '0);
    assign busy       = (state_q != IDLE);
    assign bus_out    = mdro ? mdr_q : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            mar_q        <= '0;
            mdr_q        <= '0;
            done         <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            done         <= 1'b0;
            protocol_err <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Register loads land on the same edge as a request, so the
                    // access that follows sees the freshly loaded MAR/MDR.
                    if (mari) mar_q <= bus_in[ADDR_WIDTH-1:0];
                    if (mdri) mdr_q <= bus_in;
                    if (read) begin
                        state_q      <= READ_WAIT;
                        cnt_q        <= CNT_W'(WAIT_STATES);
                        protocol_err <= write;
                    end else if (write) begin
                        state_q <= WRITE_WAIT;
                        cnt_q   <= CNT_W'(WAIT_STATES);
                    end
                end
                READ_WAIT: begin
                    protocol_err <= strobe_any;
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        mdr_q   <= mem_q[mar_q];
                        state_q <= DONE;
                        done    <= 1'b1;
                    end
                end
                WRITE_WAIT: begin
                    protocol_err <= strobe_any;
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        state_q <= DONE;
                        done    <= 1'b1;
                    end
                end
                DONE: begin
                    protocol_err <= strobe_any;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // RAM is not reset; gating with reset keeps an aborted write out of memory.
    always_ff @(posedge clock) begin
        if (mem_we_d && !reset) mem_q[mar_q] <= mdr_q;
    end

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: randomized strobes against a transaction-level
// model, with a done/protocol_err monitor and a directed zero-wait-state instance.
module tb_memory_responder;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int WS = 2;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- DUT (WAIT_STATES = 2) ----------------
  logic          mari = 0, mdri = 0, mdro = 0, read = 0, write = 0;
  logic [DW-1:0] bus_in = '0;
  logic [DW-1:0] bus_out, mdr_q;
  logic [AW-1:0] mar_q;
  logic          busy, done, protocol_err;

  memory_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(WS)) dut (
    .clock(clock), .reset(reset), .mari(mari), .mdri(mdri), .mdro(mdro),
    .read(read), .write(write), .bus_in(bus_in), .bus_out(bus_out),
    .busy(busy), .done(done), .protocol_err(protocol_err),
    .mar_q(mar_q), .mdr_q(mdr_q)
  );

  // ---------------- DUT (WAIT_STATES = 0) ----------------
  logic          z_mari = 0, z_mdri = 0, z_mdro = 0, z_read = 0, z_write = 0;
  logic [DW-1:0] z_bus_in = '0;
  logic [DW-1:0] z_bus_out, z_mdr_q;
  logic [AW-1:0] z_mar_q;
  logic          z_busy, z_done, z_protocol_err;

  memory_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(0)) dut_z (
    .clock(clock), .reset(reset), .mari(z_mari), .mdri(z_mdri), .mdro(z_mdro),
    .read(z_read), .write(z_write), .bus_in(z_bus_in), .bus_out(z_bus_out),
    .busy(z_busy), .done(z_done), .protocol_err(z_protocol_err),
    .mar_q(z_mar_q), .mdr_q(z_mdr_q)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;

  logic [DW-1:0] exp_q[$];      // MDR expected while done is high
  logic [AW-1:0] exp_mar_q[$];  // MAR expected while done is high
  int            exp_t_q[$];    // cycle on which done must be high
  int            err_q[$];      // cycles on which protocol_err must be high

  // Reference model: memory contents, register values, first edge at which
  // a new request is accepted.
  logic [DW-1:0] mem_m [1 << AW];
  logic [AW-1:0] m_mar = '0;
  logic [DW-1:0] m_mdr = '0;
  int            next_free = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver ----------------
  // One call = one clock: inputs set shortly after a rising edge are sampled
  // at the next edge, numbered cyc+1.
  task automatic issue(input bit rd, input bit wr, input bit lm, input bit ld,
                       input logic [DW-1:0] b);
    int n;
    @(posedge clock);
    #2;
    read = rd; write = wr; mari = lm; mdri = ld; bus_in = b;
    mdro = 1'($urandom_range(0, 1));
    n = cyc + 1;
    if (n >= next_free) begin
      if (lm) m_mar = b[AW-1:0];
      if (ld) m_mdr = b;
      if (rd) begin
        m_mdr = mem_m[m_mar];
        if (wr) err_q.push_back(n);
      end else if (wr) begin
        mem_m[m_mar] = m_mdr;
      end
      if (rd || wr) begin
        exp_q.push_back(m_mdr);
        exp_mar_q.push_back(m_mar);
        exp_t_q.push_back(n + WS + 1);
        next_free = n + WS + 3;
      end
    end else if (rd || wr || lm || ld) begin
      err_q.push_back(n);
    end
  endtask

  task automatic idle_n(input int k);
    for (int i = 0; i < k; i++) issue(0, 0, 0, 0, $urandom);
  endtask

  task automatic z_step(input bit rd, input bit wr, input bit lm, input bit ld,
                        input bit md, input logic [DW-1:0] b);
    @(posedge clock);
    #2;
    z_read = rd; z_write = wr; z_mari = lm; z_mdri = ld; z_mdro = md; z_bus_in = b;
    #1;
  endtask

  task automatic z_write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    z_step(0, 0, 1, 0, 0, DW'(a));
    z_step(0, 0, 0, 1, 0, d);
    z_step(0, 1, 0, 0, 0, '0);
    z_step(0, 0, 0, 0, 0, '0);
    check("z_wr_busy", DW'(z_busy), 1);
    check("z_wr_done_early", DW'(z_done), 0);
    z_step(0, 0, 0, 0, 0, '0);
    check("z_wr_done", DW'(z_done), 1);
    z_step(0, 0, 0, 0, 0, '0);
    check("z_wr_done_fall", DW'(z_done), 0);
    check("z_wr_idle", DW'(z_busy), 0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (!reset) begin
      bit exp_err;
      exp_err = (err_q.size() != 0) && (err_q[0] == cyc);
      if (exp_err) void'(err_q.pop_front());
      if (protocol_err || exp_err) check("protocol_err", DW'(protocol_err), DW'(exp_err));

      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", DW'(done), 0);
        end else begin
          logic [DW-1:0] e_d;
          logic [AW-1:0] e_a;
          int            e_t;
          e_d = exp_q.pop_front();
          e_a = exp_mar_q.pop_front();
          e_t = exp_t_q.pop_front();
          check("done_cycle", DW'(cyc), DW'(e_t));
          check("mdr_at_done", mdr_q, e_d);
          check("mar_at_done", DW'(mar_q), DW'(e_a));
          check("bus_out", bus_out, mdro ? e_d : '0);
        end
      end else if (exp_t_q.size() != 0 && exp_t_q[0] < cyc) begin
        check("missing_done", DW'(done), 1);
        void'(exp_q.pop_front());
        void'(exp_mar_q.pop_front());
        void'(exp_t_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clock);
    #2;
    check("rst_mar", DW'(mar_q), 0);
    check("rst_mdr", mdr_q, 0);
    check("rst_busy", DW'(busy), 0);
    check("rst_done", DW'(done), 0);
    check("rst_err", DW'(protocol_err), 0);
    reset = 0;

    // Zero-wait-state instance: boundary addresses, back-to-back reads.
    z_write_word(9'h1FF, 32'hA5A5_0F0F);
    z_write_word(9'h000, 32'h5A5A_F0F0);
    z_step(0, 0, 1, 0, 0, 32'h0000_01FF);
    z_step(1, 0, 0, 0, 0, '0);
    z_step(0, 0, 0, 0, 0, '0);
    check("z_rd_busy", DW'(z_busy), 1);
    check("z_rd_done_early", DW'(z_done), 0);
    z_step(0, 0, 0, 0, 1, '0);
    check("z_rd1_done", DW'(z_done), 1);
    check("z_rd1_mdr", z_mdr_q, 32'hA5A5_0F0F);
    check("z_rd1_bus_out", z_bus_out, 32'hA5A5_0F0F);
    z_step(1, 0, 1, 0, 0, '0);
    check("z_rd1_done_fall", DW'(z_done), 0);
    check("z_bus_out_off", z_bus_out, 0);
    z_step(0, 0, 0, 0, 0, '0);
    check("z_rd2_mar", DW'(z_mar_q), 0);
    z_step(0, 0, 0, 0, 0, '0);
    check("z_rd2_done", DW'(z_done), 1);
    check("z_rd2_mdr", z_mdr_q, 32'h5A5A_F0F0);
    check("z_err_quiet", DW'(z_protocol_err), 0);

    // Write then read address 5, including a truncated MAR load.
    issue(0, 0, 1, 0, 32'h0000_0005);
    issue(0, 0, 0, 1, 32'hDEAD_BEEF);
    issue(0, 1, 0, 0, '0);
    idle_n(WS + 2);
    issue(0, 0, 1, 1, 32'hFFFF_FE05);
    issue(1, 0, 0, 0, '0);
    idle_n(WS + 2);

    // Fill every word so random reads always hit defined data.
    for (int a = 0; a < (1 << AW); a++) begin
      issue(0, 1, 1, 1, {$urandom_range(0, (1 << (DW - AW)) - 1), 9'(a)});
      idle_n(WS + 2);
    end

    // Random strobes: conflicts, strobes while busy, held reads, boundaries.
    for (int i = 0; i < 700; i++) begin
      logic [DW-1:0] b;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b[AW-1:0] = $urandom_range(0, 1) ? 9'h1FF : 9'h000;
      issue($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 30,
            $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 35, b);
    end
    idle_n(WS + 3);

    // Reset during WRITE_WAIT with one wait state left: the write is lost.
    issue(0, 0, 1, 0, 32'h0000_0007);
    issue(0, 1, 0, 1, 32'h1111_1111);
    idle_n(WS + 2);
    issue(0, 1, 0, 1, 32'h2222_2222);
    idle_n(2);
    reset = 1;
    exp_q.delete(); exp_mar_q.delete(); exp_t_q.delete(); err_q.delete();
    mem_m[7] = 32'h1111_1111;
    m_mar = '0; m_mdr = '0; next_free = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #2;
      check("abort_done", DW'(done), 0);
    end
    check("abort_busy", DW'(busy), 0);
    check("abort_mar", DW'(mar_q), 0);
    check("abort_mdr", mdr_q, 0);
    read = 0; write = 0; mari = 0; mdri = 0;
    reset = 0;
    idle_n(4);
    issue(1, 0, 1, 0, 32'h0000_0007);
    idle_n(WS + 2);

    // Drain, bounded.
    for (int i = 0; i < 50 && exp_t_q.size() != 0; i++) idle_n(1);
    if (exp_t_q.size() != 0) check("drain_timeout", DW'(exp_t_q.size()), 0);
    check("err_queue_empty", DW'(err_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
